// File: rtl/prm_pkg.sv
// Shared definitions for the prm register primitives: skid-buffer state
// encoding and the occupancy level width.
package prm_pkg;

    localparam logic [1:0] SKID_EMPTY = 2'b00;
    localparam logic [1:0] SKID_ONE   = 2'b01;
    localparam logic [1:0] SKID_TWO   = 2'b10;

    localparam int LEVEL_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = SKID_EMPTY,
        ST_ONE   = SKID_ONE,
        ST_TWO   = SKID_TWO
    } skid_state_e;

endpackage

// File: rtl/prm_skid_buffer_if.sv
// Valid/ready handshake bundle around the skid buffer: upstream (s_*) and
// downstream (m_*) sides. The buffer uses the slave view, its environment the master view.
interface prm_skid_buffer_if #(
    parameter int WIDTH = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/prm_skid_ctrl.sv
// Occupancy FSM of the skid buffer; emits the register load strobes that the
// datapath in prm_skid_buffer acts on. Flush overrides every transition.
module prm_skid_ctrl
    import prm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_n,
    input  logic        s_valid,
    input  logic        m_ready,
    output skid_state_e state,
    output logic        load_main,
    output logic        load_skid,
    output logic        main_from_skid
);

    skid_state_e state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (s_valid) begin
                    load_main = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (s_valid && m_ready) begin
                    load_main = 1'b1;
                end else if (s_valid) begin
                    load_skid = 1'b1;
                    state_nxt = ST_TWO;
                end else if (m_ready) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // s_ready is low here, so any upstream s_valid is ignored
                if (m_ready) begin
                    main_from_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (!clr_n) begin
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
            state_nxt      = ST_EMPTY;
        end
    end

endmodule

// File: rtl/prm_skid_buffer.sv
// Two-entry valid/ready skid buffer with registered forward and backward paths.
// Optional occupancy output enabled by PRM_SKID_BUFFER_OCCUPANCY_EN.
module prm_skid_buffer
    import prm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_n,
    prm_skid_buffer_if.slave   bus
`ifdef PRM_SKID_BUFFER_OCCUPANCY_EN
    ,
    output logic [LEVEL_W-1:0] level
`endif
);

    skid_state_e      state;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_data_p1;
    logic [WIDTH-1:0] skid_data_p1;

    prm_skid_ctrl u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_n          (clr_n),
        .s_valid        (bus.s_valid),
        .m_ready        (bus.m_ready),
        .state          (state),
        .load_main      (load_main),
        .load_skid      (load_skid),
        .main_from_skid (main_from_skid)
    );

    // Stage p1: main register feeds the consumer, skid catches the word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_p1 <= '0;
            skid_data_p1 <= '0;
        end else if (!clr_n) begin
            main_data_p1 <= '0;
            skid_data_p1 <= '0;
        end else begin
            if (load_main) begin
                main_data_p1 <= bus.s_data;
            end else if (main_from_skid) begin
                main_data_p1 <= skid_data_p1;
            end
            if (load_skid) begin
                skid_data_p1 <= bus.s_data;
            end
        end
    end

    assign bus.m_data  = main_data_p1;
    assign bus.m_valid = (state != ST_EMPTY);
    assign bus.s_ready = (state != ST_TWO);

`ifdef PRM_SKID_BUFFER_OCCUPANCY_EN
    assign level = state;
`endif

endmodule

// File: tb/tb_prm_skid_buffer.sv
// Directed bench for prm_skid_buffer: reset, streaming, backpressure, flush,
// drain and asynchronous reset, with hand-computed expectations.
module tb_prm_skid_buffer;

    logic clk;
    logic rst_n;
    logic clr_n;
    int   n_cmp;
    int   n_err;

    prm_skid_buffer_if #(.WIDTH(8)) bus ();

`ifdef PRM_SKID_BUFFER_OCCUPANCY_EN
    logic [1:0] level;
`endif

    prm_skid_buffer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_n (clr_n),
        .bus   (bus.slave)
`ifdef PRM_SKID_BUFFER_OCCUPANCY_EN
        ,
        .level (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lvl(input string tag, input logic [7:0] exp);
`ifdef PRM_SKID_BUFFER_OCCUPANCY_EN
        chk(tag, 8'(level), exp);
`else
        if (exp > 8'd2) $display("bad level expectation for %s", tag);
`endif
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        clr_n       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;

        // Reset then idle; a word offered during reset must not be taken
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        tick();
        chk("rst_mvalid", 8'(bus.m_valid), 8'd0);
        chk("rst_sready", 8'(bus.s_ready), 8'd1);
        tick();
        rst_n       = 1'b1;
        bus.s_valid = 1'b0;
        chk("idle_mvalid", 8'(bus.m_valid), 8'd0);
        chk("idle_mdata", bus.m_data, 8'h00);
        chk("idle_sready", 8'(bus.s_ready), 8'd1);
        chk_lvl("idle_level", 8'd0);
        tick();
        chk("idle2_mvalid", 8'(bus.m_valid), 8'd0);

        // Streaming at full rate
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(16 + i);
            tick();
            chk("stream_mvalid", 8'(bus.m_valid), 8'd1);
            chk("stream_mdata", bus.m_data, 8'(16 + i));
            chk("stream_sready", 8'(bus.s_ready), 8'd1);
            chk_lvl("stream_level", 8'd1);
        end
        bus.s_valid = 1'b0;
        tick();
        chk("stream_end_mvalid", 8'(bus.m_valid), 8'd0);
        chk("stream_end_mdata", bus.m_data, 8'h17);

        // Backpressure into the skid register
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA1;
        tick();
        chk("bp1_mdata", bus.m_data, 8'hA1);
        chk("bp1_sready", 8'(bus.s_ready), 8'd1);
        bus.s_data = 8'hA2;
        tick();
        chk("bp2_sready", 8'(bus.s_ready), 8'd0);
        chk("bp2_mdata", bus.m_data, 8'hA1);
        chk("bp2_mvalid", 8'(bus.m_valid), 8'd1);
        chk_lvl("bp2_level", 8'd2);
        bus.s_data = 8'hA3;
        tick();
        chk("bp3_hold_mdata", bus.m_data, 8'hA1);
        chk("bp3_hold_sready", 8'(bus.s_ready), 8'd0);
        bus.m_ready = 1'b1;
        tick();
        chk("bp4_mdata", bus.m_data, 8'hA2);
        chk("bp4_sready", 8'(bus.s_ready), 8'd1);
        chk_lvl("bp4_level", 8'd1);
        tick();
        chk("bp5_mdata", bus.m_data, 8'hA3);
        chk("bp5_mvalid", 8'(bus.m_valid), 8'd1);
        bus.s_valid = 1'b0;
        tick();
        chk("bp6_mvalid", 8'(bus.m_valid), 8'd0);

        // Flush has priority over simultaneous transfers
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hB1;
        tick();
        bus.s_data = 8'hB2;
        tick();
        chk("fl_pre_sready", 8'(bus.s_ready), 8'd0);
        chk("fl_pre_mdata", bus.m_data, 8'hB1);
        clr_n       = 1'b0;
        bus.s_data  = 8'hB3;
        bus.m_ready = 1'b1;
        tick();
        clr_n       = 1'b1;
        bus.s_valid = 1'b0;
        chk("fl_mvalid", 8'(bus.m_valid), 8'd0);
        chk("fl_mdata", bus.m_data, 8'h00);
        chk("fl_sready", 8'(bus.s_ready), 8'd1);
        chk_lvl("fl_level", 8'd0);
        tick();
        chk("fl_after_mvalid", 8'(bus.m_valid), 8'd0);
        chk("fl_after_mdata", bus.m_data, 8'h00);

        // Drain ONE to EMPTY, data holds
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hC5;
        tick();
        chk("dr_one_mdata", bus.m_data, 8'hC5);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        chk("dr_mvalid", 8'(bus.m_valid), 8'd0);
        chk("dr_sready", 8'(bus.s_ready), 8'd1);
        chk("dr_mdata", bus.m_data, 8'hC5);

        // Asynchronous reset while holding two words
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hD1;
        tick();
        bus.s_data = 8'hD2;
        tick();
        chk("ar_pre_sready", 8'(bus.s_ready), 8'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_mvalid", 8'(bus.m_valid), 8'd0);
        chk("ar_mdata", bus.m_data, 8'h00);
        chk("ar_sready", 8'(bus.s_ready), 8'd1);
        chk_lvl("ar_level", 8'd0);
        tick();
        rst_n       = 1'b1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        chk("ar_rel_mvalid", 8'(bus.m_valid), 8'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hE1;
        tick();
        chk("ar_fresh_mdata", bus.m_data, 8'hE1);
        chk("ar_fresh_mvalid", 8'(bus.m_valid), 8'd1);
        bus.s_valid = 1'b0;
        tick();
        chk("ar_fresh_drain", 8'(bus.m_valid), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prm_skid_buffer.md
Name: prm_skid_buffer

Overview:
- Two-entry valid/ready pipeline stage; the handshaked consumer-side counterpart of the plain clear-able pipeline register.
- Sits between a producer stage and a consumer stage that may stall.
- Registers both the forward path (data/valid) and the backward path (ready), giving full throughput with no combinational path between the two handshakes.
- Synchronous flush via clr_n, matching the team's register primitives.

Parameters:
WIDTH, 8, payload width in bits

Ports:
clk      input   1      clock, all flops on rising edge
rst_n    input   1      asynchronous active-low reset
clr_n    input   1      synchronous active-low flush
s_valid  input   1      upstream data valid
s_ready  output  1      buffer can accept (decoded from state flops only)
s_data   input   WIDTH  upstream payload
m_valid  output  1      downstream data valid
m_ready  input   1      downstream accepts
m_data   output  WIDTH  downstream payload (main register)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Transfer rules: an upstream transfer occurs when s_valid & s_ready at a rising edge; a downstream transfer occurs when m_valid & m_ready.
- Storage: main register (drives m_data) and skid register.
- States: EMPTY (both free), ONE (main full), TWO (main and skid full).
- Outputs decoded from state: m_valid = (state != EMPTY); s_ready = (state != TWO).
- EMPTY:
  - s_valid -> main <= s_data, go to ONE.
  - Otherwise stay.
- ONE:
  - s_valid & m_ready -> main <= s_data, stay ONE.
  - s_valid & !m_ready -> skid <= s_data, go to TWO.
  - !s_valid & m_ready -> go to EMPTY.
  - Neither -> hold.
- TWO:
  - m_ready -> main <= skid, go to ONE.
  - Else hold. s_ready=0, so s_valid is ignored.
- Latency and throughput: one cycle from upstream accept to m_valid. Sustained throughput of 1 word/cycle when m_ready stays high.
- Ordering: strict FIFO; the skid word is always delivered after the main word.
- Data hold: m_data and m_valid remain stable while m_valid & !m_ready.
- Reset (rst_n low): state EMPTY, main and skid = 0, m_valid = 0, m_data = 0. s_ready decodes to 1, but no transfer is recognised while rst_n is low. Reset asserted mid-operation discards all content immediately.
- Flush (clr_n low at an edge): next state EMPTY, both registers = 0. Flush has priority over any simultaneous upstream or downstream transfer. A word presented that cycle is dropped; a word "taken" that cycle is still counted as consumed by downstream.
- Unused registers: no writes to main/skid except as listed above. The skid contents are don't-care in EMPTY/ONE but must be deterministic (0 after reset/flush).

Optional Feature:
- Macro: PRM_SKID_BUFFER_OCCUPANCY_EN.
- Defined: adds output port level [1:0] = 0 in EMPTY, 1 in ONE, 2 in TWO, decoded from state flops. level is 0 during reset and on the cycle after a flush.
- Undefined: the port is absent; all other behaviour is identical.

Decomposition:
- Shared package prm_pkg:
  - State encoding localparams SKID_EMPTY=2'b00, SKID_ONE=2'b01, SKID_TWO=2'b10.
  - Level width constant (2).
- Natural sub-module: prm_skid_ctrl, containing the FSM only.
  - Inputs: s_valid, m_ready, clr_n.
  - Outputs: state, load_main, load_skid, main_from_skid.
  - The datapath registers and muxes stay in the top level.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> m_valid=0, m_data=0, s_ready=1; level=0 when PRM_SKID_BUFFER_OCCUPANCY_EN is defined.
- Streaming: m_ready=1, s_valid=1 for 8 cycles with data 0x10..0x17 -> m_data shows 0x10..0x17 on consecutive cycles, each one cycle after acceptance, s_ready stays 1.
- Backpressure/skid: push 0xA1, 0xA2 with m_ready=0 -> state TWO, s_ready=0, m_data=0xA1. s_valid with 0xA3 held is not accepted. Raise m_ready -> outputs 0xA1, 0xA2, 0xA3 in order, no loss or duplication.
- Flush priority: state TWO (0xB1, 0xB2), assert clr_n=0 with s_valid=1 (0xB3) and m_ready=1 -> next cycle m_valid=0, m_data=0, s_ready=1. 0xB3 is never output.
- Drain to empty: state ONE (0xC5), s_valid=0, m_ready=1 -> next cycle m_valid=0, s_ready=1; m_data is don't-care-free (holds 0xC5).
- Async reset mid-stream: rst_n pulsed low between edges while in TWO -> m_valid drops to 0 immediately (before the next edge). After release, the buffer behaves as freshly reset.
